// File: rtl/hit_input_conditioner.sv
// rtl/hit_input_conditioner.sv - synchronise, debounce and convert mole-box presses into held hit events
// Optional drop counter built only when HIT_DROP_COUNT_EN is defined.
module hit_input_conditioner #(
    parameter int CODE_W          = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_CNT_W        = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CODE_W-1:0] box_raw,
    input  logic              game_en,
    input  logic              hit_ack,
    output logic              hit_valid,
    output logic [CODE_W-1:0] hit_code,
    output logic              box_held,
    output logic [7:0]        drop_count
);

    localparam logic [DB_CNT_W-1:0] CNT_MAX = DB_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HELD = 1'b1;

    logic [CODE_W-1:0]   sync1_q, sync1_d, sync2_q, sync2_d;
    logic [CODE_W-1:0]   cand_q, cand_d, stable_q, stable_d;
    logic [DB_CNT_W-1:0] cnt_q, cnt_d;
    logic [0:0]          state_q, state_d;
    logic                hit_valid_q, hit_valid_d;
    logic [CODE_W-1:0]   hit_code_q, hit_code_d;
    logic                hit_event;

    always_comb begin
        sync1_d = box_raw;
        sync2_d = sync1_q;

        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else begin
            cand_d = cand_q;
            cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
        stable_d = (cnt_q == CNT_MAX) ? cand_q : stable_q;

        // A new hit only arises from the idle (released) state.
        hit_event = 1'b0;
        state_d   = state_q;
        case (state_q)
            S_IDLE: begin
                if (stable_q != '0) begin
                    state_d   = S_HELD;
                    hit_event = 1'b1;
                end
            end
            default: begin
                if (stable_q == '0) begin
                    state_d = S_IDLE;
                end
            end
        endcase

        hit_valid_d = hit_valid_q;
        hit_code_d  = hit_code_q;
        if (!game_en) begin
            hit_valid_d = 1'b0;
            hit_code_d  = '0;
        end else if (hit_event && (!hit_valid_q || hit_ack)) begin
            hit_valid_d = 1'b1;
            hit_code_d  = stable_q;
        end else if (!hit_event && hit_ack) begin
            hit_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            cand_q      <= '0;
            stable_q    <= '0;
            cnt_q       <= '0;
            state_q     <= S_IDLE;
            hit_valid_q <= 1'b0;
            hit_code_q  <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            cand_q      <= cand_d;
            stable_q    <= stable_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            hit_valid_q <= hit_valid_d;
            hit_code_q  <= hit_code_d;
        end
    end

`ifdef HIT_DROP_COUNT_EN
    logic [7:0] drop_q, drop_d;
    logic       drop_event;

    assign drop_event = game_en && hit_event && hit_valid_q && !hit_ack;

    always_comb begin
        drop_d = drop_q;
        if (drop_event && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= 8'd0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;
`else
    assign drop_count = 8'd0;
`endif

    assign hit_valid = hit_valid_q;
    assign hit_code  = hit_code_q;
    assign box_held  = (state_q == S_HELD);

endmodule
